control_sequencer: RTL and testbench

//  Hardwired control unit that drives the CPU datapath's bus-select, register-load, ALU-op and memory strobes.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/reg_field_decoder.sv | 12 +
 rtl/control_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes, IR field positions and the control sequencer state set.
// The datapath ALU decodes the same opcode values.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'h00;
  localparam logic [4:0] OP_ST   = 5'h02;
  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_SUB  = 5'h04;
  localparam logic [4:0] OP_AND  = 5'h05;
  localparam logic [4:0] OP_OR   = 5'h06;
  localparam logic [4:0] OP_SHR  = 5'h07;
  localparam logic [4:0] OP_SHL  = 5'h08;
  localparam logic [4:0] OP_ADDI = 5'h0C;
  localparam logic [4:0] OP_MUL  = 5'h0F;
  localparam logic [4:0] OP_DIV  = 5'h10;
  localparam logic [4:0] OP_NOP  = 5'h1A;
  localparam logic [4:0] OP_HALT = 5'h1B;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;
  localparam int C_MSB  = 18;
  localparam int C_LSB  = 0;

  typedef enum logic [3:0] {
    ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT, ST_FAULT
  } state_e;

  function automatic logic is_rtype(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL};
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return op inside {OP_MUL, OP_DIV};
  endfunction

  // Instructions whose second operand is the C immediate (address or constant).
  function automatic logic is_imm(input logic [4:0] op);
    return op inside {OP_ADDI, OP_LD, OP_ST};
  endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// Converts a 4-bit register field into a one-hot general-register select, gated by an enable.
module reg_field_decoder (
  input  logic [3:0]  field_i,
  input  logic        en_i,
  output logic [15:0] onehot_o
);

  for (genvar gi = 0; gi < 16; gi++) begin : g_bit
    assign onehot_o[gi] = en_i && (field_i == 4'(gi));
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, decode, execute T3-T7, with a bounded memory
// handshake that traps into a sticky FAULT state.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int WAIT_MAX = 16
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Cout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        ZHighIn,
  output logic        ZLowIn,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        fault
);

  localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);

  state_e        state_q, state_d;
  logic          rst_q;
  logic [CW-1:0] wait_q, wait_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic [3:0] rin_sel, rout_sel;
  logic       rin_en, rout_en;
  logic       mem_state, timeout;
  logic [14:0] unused_ir;

  assign op        = IR[OP_MSB:OP_LSB];
  assign ra        = IR[RA_MSB:RA_LSB];
  assign rb        = IR[RB_MSB:RB_LSB];
  assign rc        = IR[RC_MSB:RC_LSB];
  assign unused_ir = IR[14:0];

  // rst_q keeps the first post-reset T0 from being consumed while clear is still low.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= ST_T0;
      rst_q   <= 1'b1;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      rst_q   <= 1'b0;
      wait_q  <= wait_d;
    end
  end

  assign mem_state = (state_q == ST_T1)
                  || (state_q == ST_T6 && op == OP_LD)
                  || (state_q == ST_T7 && op == OP_ST);
  assign timeout   = mem_state && !mem_ready && (wait_q == WAIT_LAST);

  always_comb begin
    {PCout, Zhighout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin,
     Yin, HIin, LOin, ZHighIn, ZLowIn, IncPC, Read, Write} = '0;
    alu_op   = '0;
    rin_en   = 1'b0;
    rin_sel  = ra;
    rout_en  = 1'b0;
    rout_sel = rb;
    state_d  = state_q;
    wait_d   = '0;

    if (mem_state && !mem_ready) begin
      wait_d = wait_q + CW'(1);
    end

    case (state_q)
      ST_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        state_d = ST_T1;
      end
      ST_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        if (mem_ready)    state_d = ST_T2;
        else if (timeout) state_d = ST_FAULT;
      end
      ST_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = ST_T3;
      end
      ST_T3: begin
        if (is_rtype(op) || is_imm(op) || is_muldiv(op)) begin
          rout_en  = 1'b1;
          rout_sel = is_muldiv(op) ? ra : rb;
          Yin      = 1'b1;
          state_d  = ST_T4;
        end else if (op == OP_HALT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_T0;
        end
      end
      ST_T4: begin
        ZLowIn  = 1'b1;
        state_d = ST_T5;
        if (is_rtype(op)) begin
          rout_en  = 1'b1;
          rout_sel = rc;
          alu_op   = op;
        end else if (is_muldiv(op)) begin
          rout_en  = 1'b1;
          rout_sel = rb;
          alu_op   = op;
          ZHighIn  = 1'b1;
        end else begin
          Cout   = 1'b1;
          alu_op = OP_ADD;
        end
      end
      ST_T5: begin
        Zlowout = 1'b1;
        if (is_rtype(op) || op == OP_ADDI) begin
          rin_en  = 1'b1;
          state_d = ST_T0;
        end else if (is_muldiv(op)) begin
          LOin    = 1'b1;
          state_d = ST_T6;
        end else begin
          MARin   = 1'b1;
          state_d = ST_T6;
        end
      end
      ST_T6: begin
        if (is_muldiv(op)) begin
          Zhighout = 1'b1;
          HIin     = 1'b1;
          state_d  = ST_T0;
        end else if (op == OP_LD) begin
          Read  = 1'b1;
          MDRin = 1'b1;
          if (mem_ready)    state_d = ST_T7;
          else if (timeout) state_d = ST_FAULT;
        end else if (op == OP_ST) begin
          rout_en  = 1'b1;
          rout_sel = ra;
          MDRin    = 1'b1;
          state_d  = ST_T7;
        end else begin
          state_d = ST_T0;
        end
      end
      ST_T7: begin
        if (op == OP_LD) begin
          MDRout  = 1'b1;
          rin_en  = 1'b1;
          state_d = ST_T0;
        end else if (op == OP_ST) begin
          Write = 1'b1;
          if (mem_ready)    state_d = ST_T0;
          else if (timeout) state_d = ST_FAULT;
        end else begin
          state_d = ST_T0;
        end
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_T0;
    endcase

    if (rst_q) begin
      {PCout, Zhighout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin,
       Yin, HIin, LOin, ZHighIn, ZLowIn, IncPC, Read, Write} = '0;
      alu_op  = '0;
      rin_en  = 1'b0;
      rout_en = 1'b0;
      state_d = ST_T0;
      wait_d  = '0;
    end
  end

  assign run   = !rst_q && (state_q != ST_HALT) && (state_q != ST_FAULT);
  assign fault = !rst_q && (state_q == ST_FAULT);

  reg_field_decoder u_rin_dec (
    .field_i  (rin_sel),
    .en_i     (rin_en),
    .onehot_o (Rin)
  );

  reg_field_decoder u_rout_dec (
    .field_i  (rout_sel),
    .en_i     (rout_en),
    .onehot_o (Rout)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench: each instruction is expanded into its expected per-cycle control words
// from the instruction table, then replayed against the sequencer with random memory latency.
module tb_control_sequencer;

  localparam int WAIT_MAX = 16;

  localparam logic [4:0] K_LD = 5'h00, K_ST = 5'h02, K_ADD = 5'h03, K_SUB = 5'h04;
  localparam logic [4:0] K_AND = 5'h05, K_OR = 5'h06, K_SHR = 5'h07, K_SHL = 5'h08;
  localparam logic [4:0] K_ADDI = 5'h0C, K_MUL = 5'h0F, K_DIV = 5'h10;
  localparam logic [4:0] K_NOP = 5'h1A, K_HALT = 5'h1B;

  typedef struct packed {
    logic pcout, zhighout, zlowout, mdrout, cout, marin, pcin, mdrin, irin;
    logic yin, hiin, loin, zhighin, zlowin, incpc, read, write;
    logic [15:0] rin, rout;
    logic [4:0]  alu;
    logic run, fault;
  } ctl_t;

  typedef struct {
    ctl_t  w;
    bit    mem;
    string name;
  } step_t;

  logic        clock, clear, mem_ready;
  logic [31:0] IR;
  logic PCout, Zhighout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin;
  logic Yin, HIin, LOin, ZHighIn, ZLowIn, IncPC, Read, Write;
  logic [15:0] Rin, Rout;
  logic [4:0]  alu_op;
  logic        run, fault;
  ctl_t        obs;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] cur_ir;
  step_t       steps[$];

  control_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
    .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin),
    .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .IncPC(IncPC), .Read(Read),
    .Write(Write), .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .run(run), .fault(fault)
  );

  assign obs = {PCout, Zhighout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin,
                Yin, HIin, LOin, ZHighIn, ZLowIn, IncPC, Read, Write,
                Rin, Rout, alu_op, run, fault};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (ir %08h)", tag, got, exp, cur_ir);
    end
  endtask

  function automatic logic [15:0] oh(input logic [3:0] r);
    logic [15:0] one = 16'd1;
    return one << r;
  endfunction

  function automatic ctl_t busy();
    ctl_t c = '0;
    c.run = 1'b1;
    return c;
  endfunction

  task automatic push(input ctl_t w, input bit m, input string n);
    step_t s;
    s.w = w; s.mem = m; s.name = n;
    steps.push_back(s);
  endtask

  // Expected control words for one instruction, straight from the instruction table.
  task automatic build_steps(input logic [31:0] ir);
    logic [4:0] op = ir[31:27];
    logic [3:0] ra = ir[26:23];
    logic [3:0] rb = ir[22:19];
    logic [3:0] rc = ir[18:15];
    bit   rtype  = op inside {K_ADD, K_SUB, K_AND, K_OR, K_SHR, K_SHL};
    bit   muldiv = op inside {K_MUL, K_DIV};
    bit   immed  = op inside {K_ADDI, K_LD, K_ST};
    ctl_t w;
    steps.delete();
    w = busy(); w.pcout = 1; w.marin = 1; w.incpc = 1; push(w, 0, "T0");
    w = busy(); w.read = 1; w.mdrin = 1;              push(w, 1, "T1");
    w = busy(); w.mdrout = 1; w.irin = 1;             push(w, 0, "T2");
    if (rtype) begin
      w = busy(); w.rout = oh(rb); w.yin = 1;                    push(w, 0, "T3");
      w = busy(); w.rout = oh(rc); w.alu = op; w.zlowin = 1;     push(w, 0, "T4");
      w = busy(); w.zlowout = 1; w.rin = oh(ra);                 push(w, 0, "T5");
    end else if (muldiv) begin
      w = busy(); w.rout = oh(ra); w.yin = 1;                    push(w, 0, "T3");
      w = busy(); w.rout = oh(rb); w.alu = op; w.zlowin = 1; w.zhighin = 1; push(w, 0, "T4");
      w = busy(); w.zlowout = 1; w.loin = 1;                     push(w, 0, "T5");
      w = busy(); w.zhighout = 1; w.hiin = 1;                    push(w, 0, "T6");
    end else if (immed) begin
      w = busy(); w.rout = oh(rb); w.yin = 1;                    push(w, 0, "T3");
      w = busy(); w.cout = 1; w.alu = K_ADD; w.zlowin = 1;       push(w, 0, "T4");
      if (op == K_ADDI) begin
        w = busy(); w.zlowout = 1; w.rin = oh(ra);               push(w, 0, "T5");
      end else begin
        w = busy(); w.zlowout = 1; w.marin = 1;                  push(w, 0, "T5");
        if (op == K_LD) begin
          w = busy(); w.read = 1; w.mdrin = 1;                   push(w, 1, "T6");
          w = busy(); w.mdrout = 1; w.rin = oh(ra);              push(w, 0, "T7");
        end else begin
          w = busy(); w.rout = oh(ra); w.mdrin = 1;              push(w, 0, "T6");
          w = busy(); w.write = 1;                               push(w, 1, "T7");
        end
      end
    end else begin
      w = busy(); push(w, 0, "T3");
    end
  endtask

  // One clock: inputs applied just after the edge act on the next edge; outputs checked mid-cycle.
  task automatic cycle(input bit chk, input logic mr, input logic clr, input ctl_t exp, input string tag);
    int nsrc;
    @(posedge clock);
    #1;
    IR        = cur_ir;
    mem_ready = mr;
    clear     = clr;
    @(negedge clock);
    if (chk) begin
      check(tag, 64'(obs), 64'(exp));
      nsrc = int'(PCout) + int'(Zhighout) + int'(Zlowout) + int'(MDRout) + int'(Cout) + int'(Rout != 0);
      check({tag, "_bus"}, 64'(nsrc <= 1 && $countones(Rout) <= 1 && $countones(Rin) <= 1), 64'd1);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1, 1'($urandom), (i == n - 1) ? 1'b1 : 1'b0, ctl_t'('0), "reset");
    end
  endtask

  task automatic run_instr(input logic [31:0] ir, input int d1, input int d2, input int abort_step);
    int   nmem = 0;
    int   d;
    ctl_t fw;
    $display("instr %08h op=%02h d1=%0d d2=%0d abort=%0d", ir, ir[31:27], d1, d2, abort_step);
    build_steps(ir);
    cur_ir = ir;
    for (int i = 0; i < steps.size(); i++) begin
      if (i == abort_step) begin
        if (steps[i].mem) begin
          cycle(1, 1'b0, 1'b1, steps[i].w, steps[i].name);
          cycle(1, 1'b0, 1'b1, steps[i].w, steps[i].name);
        end
        cycle(1, 1'b0, 1'b0, steps[i].w, steps[i].name);
        do_reset(2);
        return;
      end
      if (!steps[i].mem) begin
        cycle(1, 1'($urandom), 1'b1, steps[i].w, steps[i].name);
      end else begin
        d = (nmem == 0) ? d1 : d2;
        nmem++;
        for (int c = 0; c < WAIT_MAX; c++) begin
          cycle(1, (c >= d) ? 1'b1 : 1'b0, 1'b1, steps[i].w, steps[i].name);
          if (c >= d) break;
        end
        if (d >= WAIT_MAX) begin
          fw = '0;
          fw.fault = 1'b1;
          for (int k = 0; k < 4; k++) begin
            cycle(1, 1'($urandom), (k == 3) ? 1'b0 : 1'b1, fw, "fault");
          end
          do_reset(2);
          return;
        end
      end
    end
    if (ir[31:27] == K_HALT) begin
      for (int k = 0; k < 4; k++) begin
        cycle(1, 1'($urandom), (k == 3) ? 1'b0 : 1'b1, ctl_t'('0), "halt");
      end
      do_reset(2);
    end
  endtask

  function automatic logic [31:0] rand_ir();
    logic [4:0] ops [13] = '{K_LD, K_ST, K_ADD, K_SUB, K_AND, K_OR, K_SHR, K_SHL,
                             K_ADDI, K_MUL, K_DIV, K_NOP, K_HALT};
    logic [31:0] r = $urandom;
    logic [4:0]  op;
    if ($urandom_range(0, 7) == 0) op = 5'($urandom);
    else                           op = ops[$urandom_range(0, 12)];
    return {op, r[26:0]};
  endfunction

  function automatic int rand_delay();
    int p = $urandom_range(0, 31);
    if (p == 0)     return WAIT_MAX;
    else if (p < 4) return WAIT_MAX - 1;
    else            return $urandom_range(0, 4);
  endfunction

  initial begin
    clear     = 1'b0;
    mem_ready = 1'b0;
    IR        = '0;
    cur_ir    = '0;

    cycle(0, 1'b0, 1'b0, ctl_t'('0), "init");
    do_reset(2);

    run_instr(32'h18918000, 0, 0, -1);            // ADD R1,R2,R3
    run_instr(32'h02280010, 1, 3, -1);            // LD R4,0x10(R5), T6 ready after 3 waits
    run_instr(32'h7B380000, 2, 0, -1);            // MUL R6,R7
    run_instr(32'h18918000, WAIT_MAX - 1, 0, -1); // ready arrives on the last allowed cycle
    run_instr(32'h18918000, WAIT_MAX, 0, -1);     // T1 timeout -> FAULT
    run_instr(32'h10900004, 0, WAIT_MAX - 1, -1); // ST at its wait limit
    run_instr(32'h02280010, 0, WAIT_MAX, -1);     // LD T6 timeout
    run_instr(32'hD8000000, 0, 0, -1);            // HALT
    run_instr(32'h10900004, 0, 5, 7);             // ST reset while Write held in T7
    run_instr(32'hD0000000, 0, 0, -1);            // NOP
    run_instr(32'h80000000, 0, 0, 1);             // DIV, reset mid-fetch wait

    for (int n = 0; n < 70; n++) begin
      logic [31:0] ir = rand_ir();
      int ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1;
      run_instr(ir, rand_delay(), rand_delay(), ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
